vsevenseg_mux: RTL

- Parametrised, time-multiplexed hex display driver for an N-digit common-anode seven-segment display. Active-low segment, decimal-point and anode outputs.
- Captures a packed N-nibble value and decimal points on a load strobe, then scans the digits at a programmable refresh rate.
- Adds anti-ghosting blanking, leading-zero suppression and per-digit blink.
- Sits between the datapath and the board display pins, replacing the single-digit combinational decoder.

---
 rtl/vsevenseg_mux_if.sv | 28 ++
 rtl/vsevenseg_mux.sv | 133 +++++++++++++
 2 files changed

// File: rtl/vsevenseg_mux_if.sv
// Bundle of the display-driver datapath inputs and the active-low pin outputs.
// Handshake: there is no valid/ready pair; 'load' is a single-cycle qualifier
// for value/dp sampled on the rising clock edge, and every other input is live.
interface vsevenseg_mux_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp;
  logic                    load;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    lz_blank;
  logic [NUM_DIGITS-1:0]   blink;
  logic [6:0]              seg_L;
  logic                    dp_L;
  logic [NUM_DIGITS-1:0]   anode_L;

  // Datapath side: drives the data and controls, observes the pins.
  modport master (
    output value, dp, load, digit_en, lz_blank, blink,
    input  seg_L, dp_L, anode_L
  );

  // Display driver side.
  modport slave (
    input  value, dp, load, digit_en, lz_blank, blink,
    output seg_L, dp_L, anode_L
  );
endinterface

// File: rtl/vsevenseg_mux.sv
// Time-multiplexed hex driver for an N-digit common-anode seven-segment display.
// Scans one digit per REFRESH_DIV-cycle slot, darkens the first BLANK_CYCLES of
// each slot against ghosting, and supports leading-zero suppression and blink.
module vsevenseg_mux #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int BLINK_DIV    = 25000000
) (
  input logic              clk,
  input logic              rst_n,
  vsevenseg_mux_if.slave   bus
);

  localparam int CNT_W   = $clog2(REFRESH_DIV);
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0]   BLANK_END = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0]   IDX_MAX   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_DIV - 1);

  logic [4*NUM_DIGITS-1:0] val_q;
  logic [NUM_DIGITS-1:0]   dp_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [IDX_W-1:0]        idx_q;
  logic [BLINK_W-1:0]      blink_cnt_q;
  logic                    blink_phase_q;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_out_q, dp_out_d;
  logic [NUM_DIGITS-1:0]   anode_q, anode_d;

  logic [NUM_DIGITS-1:0]   upper_zero;
  logic                    lz_hit;
  logic                    visible;
  logic [3:0]              cur_nib;

  function automatic logic [6:0] glyph(input logic [3:0] nib);
    case (nib)
      4'h0: glyph = 7'h3F;  4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;  4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;  4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;  4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;  4'h9: glyph = 7'h6F;
      4'hA: glyph = 7'h77;  4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;  4'hD: glyph = 7'h5E;
      4'hE: glyph = 7'h79;  default: glyph = 7'h71;
    endcase
  endfunction

  // Shadow copy of the displayed data; only 'load' updates it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      val_q <= '0;
      dp_q  <= '0;
    end else if (bus.load) begin
      val_q <= bus.value;
      dp_q  <= bus.dp;
    end
  end

  // Slot counter and digit index; index advances when a slot completes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_q <= '0;
      idx_q <= (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Free-running blink timer; phase toggles once per half-period.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else if (blink_cnt_q == BLINK_MAX) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= ~blink_phase_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + 1'b1;
    end
  end

  // upper_zero[i] is set when shadow nibbles i..NUM_DIGITS-1 are all zero.
  always_comb begin
    logic acc;
    acc        = 1'b1;
    upper_zero = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      acc           = acc & (val_q[4*i +: 4] == 4'h0);
      upper_zero[i] = acc;
    end
  end

  // Visibility of the current digit and the next pin values.
  always_comb begin
    cur_nib  = val_q[4*idx_q +: 4];
    lz_hit   = bus.lz_blank && (idx_q != '0) && upper_zero[idx_q];
    visible  = (cnt_q >= BLANK_END) && bus.digit_en[idx_q] &&
               !(bus.blink[idx_q] && blink_phase_q) && !lz_hit;
    seg_d    = 7'h7F;
    dp_out_d = 1'b1;
    anode_d  = '1;
    if (visible) begin
      seg_d    = ~glyph(cur_nib);
      dp_out_d = ~dp_q[idx_q];
      anode_d  = ~(NUM_DIGITS'(1) << idx_q);
    end
  end

  // Registered pins so the anodes and segments switch together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_q    <= 7'h7F;
      dp_out_q <= 1'b1;
      anode_q  <= '1;
    end else begin
      seg_q    <= seg_d;
      dp_out_q <= dp_out_d;
      anode_q  <= anode_d;
    end
  end

  assign bus.seg_L   = seg_q;
  assign bus.dp_L    = dp_out_q;
  assign bus.anode_L = anode_q;

endmodule
